// File: rtl/ram_stream_reader_pkg.sv
// Shared constants for the ROM loader / dual-port RAM / stream reader slice.
// State encodings for the reader FSM live here so the bench and RTL agree on names.
package ram_stream_reader_pkg;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;
endpackage

// File: rtl/ram_stream_reader_if.sv
// Control, RAM read port and output stream of the RAM stream reader.
// master = the reader, slave = the environment (sequencer, RAM, consumer).
interface ram_stream_reader_if
  import ram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  finish;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start, base_addr, length, ram_rd_data, out_ready,
    output busy, finish, ram_rd_en, ram_rd_addr, out_data, out_valid
  );

  modport slave (
    output start, base_addr, length, ram_rd_data, out_ready,
    input  busy, finish, ram_rd_en, ram_rd_addr, out_data, out_valid
  );
endinterface

// File: rtl/ram_stream_reader_stream_skid_fifo.sv
// Two-entry FIFO that catches registered RAM read data and presents its head
// as a valid/ready stream word.
module stream_skid_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_valid_o,
  output logic [1:0]            count_o
);
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_q;
  logic                  rd_q;
  logic [1:0]            cnt_q;
  logic [1:0]            cnt_d;
  logic                  pop_ok;

  assign pop_ok = pop_i && (cnt_q != 2'd0);
  assign cnt_d  = cnt_q + {1'b0, push_i} - {1'b0, pop_ok};

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign head_data_o  = mem_q[rd_q];
  assign head_valid_o = (cnt_q != 2'd0);
  assign count_o      = cnt_q;
endmodule

// File: rtl/ram_stream_reader.sv
// Reads a contiguous block out of the dual-port RAM and streams it to a consumer.
//   state | meaning
//   IDLE  | waiting for start; base/length latched on start
//   RUN   | issuing reads while the FIFO plus in-flight read has room
//   DRAIN | all reads issued, waiting for the remaining handshakes
//   DONE  | one-cycle finish pulse
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  ram_stream_reader_if.master bus
);
  localparam int LW = ADDR_WIDTH + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         issued_q, issued_d;
  logic [LW-1:0]         accepted_q, accepted_d;
  logic                  inflight_q;

  logic                  rd_en;
  logic                  busy;
  logic                  finish;
  logic                  pop;
  logic                  start_ok;
  logic                  fifo_valid;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [2:0]            occupancy;

  assign pop       = fifo_valid && bus.out_ready;
  assign start_ok  = (state_q == ST_IDLE) && bus.start;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Zero-length runs pass through DRAIN so busy still shows for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = (bus.length == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (issued_d == len_q) state_d = ST_DRAIN;
      ST_DRAIN: if (accepted_d == len_q) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en  = 1'b0;
    busy   = 1'b0;
    finish = 1'b0;
    case (state_q)
      ST_RUN: begin
        busy  = 1'b1;
        rd_en = (issued_q < len_q) && (occupancy < (3'd2 + {2'b00, pop}));
      end
      ST_DRAIN: busy   = 1'b1;
      ST_DONE:  finish = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q + {{(LW-1){1'b0}}, rd_en};
    accepted_d = accepted_q + {{(LW-1){1'b0}}, pop};
    if (start_ok) begin
      base_d     = bus.base_addr;
      len_d      = bus.length;
      issued_d   = '0;
      accepted_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      inflight_q <= rd_en;
    end
  end

  stream_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (inflight_q),
    .push_data_i  (bus.ram_rd_data),
    .pop_i        (pop),
    .head_data_o  (fifo_data),
    .head_valid_o (fifo_valid),
    .count_o      (fifo_count)
  );

  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = base_q + issued_q[ADDR_WIDTH-1:0];
  assign bus.out_data    = fifo_data;
  assign bus.out_valid   = fifo_valid;
  assign bus.busy        = busy;
  assign bus.finish      = finish;
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: a RAM model, randomized runs and
// backpressure, with expected addresses/words queued when each run starts.
module tb_ram_stream_reader;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rdy_mode = 0;
  int phase = 0;
  always @(posedge clk) begin
    #1;
    phase++;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ((phase % 3) == 0);
      default: bus.out_ready = $urandom_range(0, 1) == 1;
    endcase
  end

  int exp_addr [$];
  int exp_data [$];

  int rd_cnt, hs_cnt, valid_cnt, rd_tot, hs_tot, max_out;
  int first_hs, last_hs, busy_first, busy_last, finish_cyc;
  bit finish_seen;
  bit prev_valid, prev_ready;
  logic [DW-1:0] prev_data;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues a read or completes a handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.ram_rd_en) begin
        rd_cnt++;
        rd_tot++;
        if (exp_addr.size() == 0) check("unexpected_read", {20'd0, bus.ram_rd_addr}, 32'hFFFF_FFFF);
        else check("rd_addr", {20'd0, bus.ram_rd_addr}, exp_addr.pop_front());
      end
      if (prev_valid && !prev_ready) begin
        check("valid_held", {31'd0, bus.out_valid}, 1);
        check("data_held", {24'd0, bus.out_data}, {24'd0, prev_data});
      end
      if (bus.out_valid) valid_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        hs_tot++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (exp_data.size() == 0) check("unexpected_word", {24'd0, bus.out_data}, 32'hFFFF_FFFF);
        else check("out_data", {24'd0, bus.out_data}, exp_data.pop_front());
      end
      if (rd_tot - hs_tot > max_out) max_out = rd_tot - hs_tot;
      if (bus.busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (bus.finish) begin
        finish_seen = 1'b1;
        finish_cyc  = cyc;
        check("busy_low_at_finish", {31'd0, bus.busy}, 0);
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  int t0;

  task automatic start_run(input int base, input int len);
    @(posedge clk);
    #1;
    for (int k = 0; k < len; k++) begin
      exp_addr.push_back((base + k) % DEPTH);
      exp_data.push_back(int'(mem[(base + k) % DEPTH]));
    end
    rd_cnt = 0; hs_cnt = 0; valid_cnt = 0; rd_tot = 0; hs_tot = 0; max_out = 0;
    first_hs = -1; last_hs = -1; busy_first = -1; busy_last = -1; finish_cyc = -1;
    finish_seen = 1'b0;
    t0 = cyc;
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.length    = (AW+1)'(len);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_finish(input int limit);
    for (int i = 0; i < limit && !finish_seen; i++) @(negedge clk);
    check("finish_seen", {31'd0, finish_seen}, 1);
  endtask

  task automatic do_run(input int base, input int len, input int mode);
    rdy_mode = mode;
    start_run(base, len);
    wait_finish(len * 8 + 50);
    check("handshakes", hs_cnt, len);
    check("read_pulses", rd_cnt, len);
    check("max_outstanding_le2", {31'd0, max_out <= 2}, 1);
    check("queues_drained", exp_data.size() + exp_addr.size(), 0);
    if (len > 0) check("finish_after_last_hs", finish_cyc, last_hs + 1);
    if (mode == 0 && len > 0) begin
      check("first_valid_C3", first_hs, t0 + 3);
      check("last_hs", last_hs, t0 + 2 + len);
      check("finish_cycle", finish_cyc, t0 + 3 + len);
      check("busy_first", busy_first, t0 + 1);
      check("busy_last", busy_last, t0 + 2 + len);
    end
  endtask

  initial begin
    int vc0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", {31'd0, bus.ram_rd_en}, 0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_finish", {31'd0, bus.finish}, 0);
    check("rst_rd_addr", {20'd0, bus.ram_rd_addr}, 0);
    check("rst_out_data", {24'd0, bus.out_data}, 0);
    reset = 1'b0;

    do_run(12'h010, 4, 0);
    do_run(12'h020, 8, 1);

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    do_run(12'hFFE, 4, 2);

    rdy_mode = 0;
    start_run(12'h123, 0);
    wait_finish(20);
    check("zero_no_reads", rd_cnt, 0);
    check("zero_no_valid", valid_cnt, 0);
    check("zero_finish_C2", finish_cyc, t0 + 2);
    check("zero_busy_first", busy_first, t0 + 1);
    check("zero_busy_last", busy_last, t0 + 1);

    do_run(12'h800, DEPTH, 0);

    for (int r = 0; r < 12; r++) do_run($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), r % 3);

    // Reset in the middle of a run: no stale word may surface afterwards.
    rdy_mode = 0;
    start_run(12'h300, 16);
    for (int i = 0; i < 200 && hs_cnt < 5; i++) @(negedge clk);
    check("mid_run_hs_reached", {31'd0, hs_cnt >= 5}, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_data.delete();
    exp_addr.delete();
    check("mid_rst_rd_en", {31'd0, bus.ram_rd_en}, 0);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("mid_rst_busy", {31'd0, bus.busy}, 0);
    check("mid_rst_finish", {31'd0, bus.finish}, 0);
    check("mid_rst_rd_addr", {20'd0, bus.ram_rd_addr}, 0);
    check("mid_rst_out_data", {24'd0, bus.out_data}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    vc0 = valid_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_word", valid_cnt, vc0);

    // Length-2 run with start pulses during RUN and in the finish cycle.
    start_run(12'h055, 2);
    bus.start = 1'b1;
    bus.base_addr = 12'h700;
    bus.length = 13'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 20 && cyc < t0 + 5; i++) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("ign_finish_cycle", finish_cyc, t0 + 5);
    check("ign_reads", rd_cnt, 2);
    check("ign_handshakes", hs_cnt, 2);
    check("ign_busy_last", busy_last, t0 + 4);
    check("ign_queues_drained", exp_data.size() + exp_addr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
